// File: rtl/axi_fifo_bridge_mc.sv
// axi_fifo_bridge_mc
// AXI4-Lite subordinate that exposes NUM_CH independent FWFT FIFO pairs.
// Each channel owns a 16-byte window: offset 0x0 is DATA (write = push,
// read = pop), offset 0x4 is STATUS {underflow, overflow, full, empty},
// offsets 0x8/0xC are reserved. One transaction per direction is in flight
// at a time; the read and write paths run independently.
//
// Ports:
//   aclk, aresetn            clock, synchronous active-low reset
//   s_axi_aw*/w*/b*          AXI4-Lite write address / data / response
//   s_axi_ar*/r*             AXI4-Lite read address / data
//   fifo_wr_data, fifo_wr_en push data (shared) and one-hot push strobe
//   fifo_full                per-channel full
//   fifo_rd_data             FWFT head words, channel i at [i*DW +: DW]
//   fifo_rd_en, fifo_empty   one-hot pop strobe, per-channel empty
module axi_fifo_bridge_mc #(
    parameter int AXI_ADDR_WIDTH = 8,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int NUM_CH = 4,
    parameter logic [NUM_CH-1:0] WRITE_EN_MASK = '1,
    parameter logic [NUM_CH-1:0] READ_EN_MASK = '1
) (
    input  logic                             aclk,
    input  logic                             aresetn,
    input  logic [AXI_ADDR_WIDTH-1:0]        s_axi_awaddr,
    input  logic                             s_axi_awvalid,
    output logic                             s_axi_awready,
    input  logic [AXI_DATA_WIDTH-1:0]        s_axi_wdata,
    input  logic [3:0]                       s_axi_wstrb,
    input  logic                             s_axi_wvalid,
    output logic                             s_axi_wready,
    output logic [1:0]                       s_axi_bresp,
    output logic                             s_axi_bvalid,
    input  logic                             s_axi_bready,
    input  logic [AXI_ADDR_WIDTH-1:0]        s_axi_araddr,
    input  logic                             s_axi_arvalid,
    output logic                             s_axi_arready,
    output logic [AXI_DATA_WIDTH-1:0]        s_axi_rdata,
    output logic [1:0]                       s_axi_rresp,
    output logic                             s_axi_rvalid,
    input  logic                             s_axi_rready,
    output logic [AXI_DATA_WIDTH-1:0]        fifo_wr_data,
    output logic [NUM_CH-1:0]                fifo_wr_en,
    input  logic [NUM_CH-1:0]                fifo_full,
    input  logic [NUM_CH*AXI_DATA_WIDTH-1:0] fifo_rd_data,
    output logic [NUM_CH-1:0]                fifo_rd_en,
    input  logic [NUM_CH-1:0]                fifo_empty
);

    localparam int DW   = AXI_DATA_WIDTH;
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CH_N = 1 << CH_W;
    localparam logic [CH_W:0] NUM_CH_L = (CH_W + 1)'(NUM_CH);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] OFF_DATA    = 2'd0;
    localparam logic [1:0] OFF_STATUS  = 2'd1;

    localparam logic [1:0] K_ERR    = 2'd0;
    localparam logic [1:0] K_POP    = 2'd1;
    localparam logic [1:0] K_STATUS = 2'd2;

    typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_EXEC, R_RESP} r_state_t;

    // Per-channel views padded to a power of two so a decoded channel
    // index can never address past the end; pad entries read as disabled.
    logic [CH_N-1:0] full_ext;
    logic [CH_N-1:0] empty_ext;
    logic [CH_N-1:0] wr_mask_ext;
    logic [CH_N-1:0] rd_mask_ext;
    logic [DW-1:0]   head_ext   [CH_N];
    logic [DW-1:0]   status_ext [CH_N];

    // ---------------- write path signals ----------------
    w_state_t                  w_state_reg, w_state_next;
    logic                      aw_held_reg, w_held_reg;
    logic [AXI_ADDR_WIDTH-1:0] awaddr_reg;
    logic [DW-1:0]             wdata_reg;
    logic [3:0]                wstrb_reg;
    logic [1:0]                bresp_reg;
    logic [NUM_CH-1:0]         wr_en_reg, wr_en_next;
    logic [DW-1:0]             wr_data_reg;

    logic                      aw_hs, w_hs, w_fire;
    logic [AXI_ADDR_WIDTH-1:0] w_addr;
    logic [DW-1:0]             w_data_sel;
    logic [3:0]                w_strb_sel;
    logic [CH_W-1:0]           w_ch;
    logic [1:0]                w_off;
    logic                      w_ch_ok, w_is_data, w_is_status;
    logic                      w_data_ok, w_push, w_ovf_set, w_okay;

    // ---------------- read path signals ----------------
    r_state_t          r_state_reg, r_state_next;
    logic [1:0]        r_kind_reg;
    logic [CH_W-1:0]   r_ch_reg;
    logic [NUM_CH-1:0] rd_en_reg, rd_en_next;
    logic [DW-1:0]     rdata_reg;
    logic [1:0]        rresp_reg;

    logic              r_fire;
    logic [CH_W-1:0]   r_ch;
    logic [1:0]        r_off;
    logic              r_ch_ok, r_is_data, r_is_status, r_pop, r_unf_set;
    logic [1:0]        r_kind;
    logic [DW-1:0]     r_rdata_exec;

    // Address bits outside channel/offset fields are don't-care.
    logic unused_bits;
    assign unused_bits = ^{w_addr, s_axi_araddr};

    // ---------------- per-channel state ----------------
    generate
        for (genvar gi = 0; gi < CH_N; gi++) begin : g_ch
            if (gi < NUM_CH) begin : g_real
                logic ovf_reg;
                logic unf_reg;
                logic ovf_set, ovf_clr, unf_set, unf_clr;

                assign ovf_set = w_fire && w_ovf_set && (w_ch == CH_W'(gi));
                assign ovf_clr = w_fire && w_is_status && (w_ch == CH_W'(gi)) && w_data_sel[2];
                assign unf_set = r_fire && r_unf_set && (r_ch == CH_W'(gi));
                assign unf_clr = w_fire && w_is_status && (w_ch == CH_W'(gi)) && w_data_sel[3];

                // Set has priority over a same-cycle write-1-to-clear.
                always_ff @(posedge aclk) begin
                    if (!aresetn) begin
                        ovf_reg <= 1'b0;
                        unf_reg <= 1'b0;
                    end else begin
                        ovf_reg <= (ovf_reg && !ovf_clr) || ovf_set;
                        unf_reg <= (unf_reg && !unf_clr) || unf_set;
                    end
                end

                assign full_ext[gi]    = fifo_full[gi];
                assign empty_ext[gi]   = fifo_empty[gi];
                assign wr_mask_ext[gi] = WRITE_EN_MASK[gi];
                assign rd_mask_ext[gi] = READ_EN_MASK[gi];
                assign head_ext[gi]    = fifo_rd_data[gi*DW +: DW];
                assign status_ext[gi]  = {{(DW-4){1'b0}}, unf_reg, ovf_reg,
                                          fifo_full[gi], fifo_empty[gi]};
                assign wr_en_next[gi]  = w_fire && w_push && (w_ch == CH_W'(gi));
                assign rd_en_next[gi]  = r_fire && r_pop && (r_ch == CH_W'(gi));
            end else begin : g_pad
                assign full_ext[gi]    = 1'b0;
                assign empty_ext[gi]   = 1'b1;
                assign wr_mask_ext[gi] = 1'b0;
                assign rd_mask_ext[gi] = 1'b0;
                assign head_ext[gi]    = '0;
                assign status_ext[gi]  = '0;
            end
        end
    endgenerate

    // ---------------- write path ----------------
    assign aw_hs = s_axi_awvalid && s_axi_awready;
    assign w_hs  = s_axi_wvalid && s_axi_wready;

    // The transaction is decided on the cycle the second half arrives, so
    // the registered push strobe lands in the W_EXEC cycle itself.
    assign w_addr     = aw_held_reg ? awaddr_reg : s_axi_awaddr;
    assign w_data_sel = w_held_reg ? wdata_reg : s_axi_wdata;
    assign w_strb_sel = w_held_reg ? wstrb_reg : s_axi_wstrb;
    assign w_fire     = (w_state_reg == W_IDLE) && (aw_held_reg || aw_hs)
                        && (w_held_reg || w_hs);

    assign w_ch        = w_addr[4 +: CH_W];
    assign w_off       = w_addr[3:2];
    assign w_ch_ok     = {1'b0, w_ch} < NUM_CH_L;
    assign w_is_data   = w_ch_ok && (w_off == OFF_DATA);
    assign w_is_status = w_ch_ok && (w_off == OFF_STATUS);
    // Partial strobes are rejected before the full check, so they never
    // raise overflow.
    assign w_data_ok   = w_is_data && wr_mask_ext[w_ch] && (w_strb_sel == 4'hF);
    assign w_push      = w_data_ok && !full_ext[w_ch];
    assign w_ovf_set   = w_data_ok && full_ext[w_ch];
    assign w_okay      = w_push || w_is_status;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            w_state_reg <= W_IDLE;
        end else begin
            w_state_reg <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = w_state_reg;
        case (w_state_reg)
            W_IDLE:  if (w_fire) w_state_next = W_EXEC;
            W_EXEC:  w_state_next = W_RESP;
            W_RESP:  if (s_axi_bready) w_state_next = W_IDLE;
            default: w_state_next = W_IDLE;
        endcase
    end

    always_comb begin
        s_axi_awready = aresetn && (w_state_reg == W_IDLE) && !aw_held_reg;
        s_axi_wready  = aresetn && (w_state_reg == W_IDLE) && !w_held_reg;
        s_axi_bvalid  = (w_state_reg == W_RESP);
        s_axi_bresp   = bresp_reg;
        fifo_wr_en    = wr_en_reg;
        fifo_wr_data  = wr_data_reg;
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            aw_held_reg <= 1'b0;
            w_held_reg  <= 1'b0;
            awaddr_reg  <= '0;
            wdata_reg   <= '0;
            wstrb_reg   <= '0;
            bresp_reg   <= RESP_OKAY;
            wr_en_reg   <= '0;
            wr_data_reg <= '0;
        end else begin
            wr_en_reg <= wr_en_next;
            if (w_fire) begin
                aw_held_reg <= 1'b0;
                w_held_reg  <= 1'b0;
                bresp_reg   <= w_okay ? RESP_OKAY : RESP_SLVERR;
                if (w_push) begin
                    wr_data_reg <= w_data_sel;
                end
            end else begin
                if (aw_hs) begin
                    aw_held_reg <= 1'b1;
                    awaddr_reg  <= s_axi_awaddr;
                end
                if (w_hs) begin
                    w_held_reg <= 1'b1;
                    wdata_reg  <= s_axi_wdata;
                    wstrb_reg  <= s_axi_wstrb;
                end
            end
        end
    end

    // ---------------- read path ----------------
    assign r_fire      = s_axi_arvalid && s_axi_arready;
    assign r_ch        = s_axi_araddr[4 +: CH_W];
    assign r_off       = s_axi_araddr[3:2];
    assign r_ch_ok     = {1'b0, r_ch} < NUM_CH_L;
    assign r_is_data   = r_ch_ok && (r_off == OFF_DATA);
    assign r_is_status = r_ch_ok && (r_off == OFF_STATUS);
    assign r_pop       = r_is_data && rd_mask_ext[r_ch] && !empty_ext[r_ch];
    assign r_unf_set   = r_is_data && rd_mask_ext[r_ch] && empty_ext[r_ch];
    assign r_kind      = r_pop ? K_POP : (r_is_status ? K_STATUS : K_ERR);

    // In R_EXEC the pop strobe is high and the FWFT head still shows the
    // word being popped; status is sampled in this same cycle.
    always_comb begin
        r_rdata_exec = '0;
        case (r_kind_reg)
            K_POP:    r_rdata_exec = head_ext[r_ch_reg];
            K_STATUS: r_rdata_exec = status_ext[r_ch_reg];
            default:  r_rdata_exec = '0;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state_reg <= R_IDLE;
        end else begin
            r_state_reg <= r_state_next;
        end
    end

    always_comb begin
        r_state_next = r_state_reg;
        case (r_state_reg)
            R_IDLE:  if (r_fire) r_state_next = R_EXEC;
            R_EXEC:  r_state_next = R_RESP;
            R_RESP:  if (s_axi_rready) r_state_next = R_IDLE;
            default: r_state_next = R_IDLE;
        endcase
    end

    always_comb begin
        s_axi_arready = aresetn && (r_state_reg == R_IDLE);
        s_axi_rvalid  = (r_state_reg == R_RESP);
        s_axi_rdata   = rdata_reg;
        s_axi_rresp   = rresp_reg;
        fifo_rd_en    = rd_en_reg;
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_kind_reg <= K_ERR;
            r_ch_reg   <= '0;
            rd_en_reg  <= '0;
            rdata_reg  <= '0;
            rresp_reg  <= RESP_OKAY;
        end else begin
            rd_en_reg <= rd_en_next;
            if (r_fire) begin
                r_kind_reg <= r_kind;
                r_ch_reg   <= r_ch;
            end
            if (r_state_reg == R_EXEC) begin
                rdata_reg <= r_rdata_exec;
                rresp_reg <= (r_kind_reg == K_ERR) ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

endmodule

// File: tb/tb_axi_fifo_bridge_mc.sv
// Directed testbench for axi_fifo_bridge_mc. dut0 has four channels with
// channel 3 pop-disabled; dut1 has three channels for decode checks. The
// AXI inputs are shared, valids are steered by sel and outputs are muxed.
module tb_axi_fifo_bridge_mc;

    logic         aclk = 1'b0;
    logic         aresetn = 1'b0;
    logic         sel = 1'b0;
    logic [7:0]   awaddr = '0, araddr = '0;
    logic         awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0;
    logic         arvalid = 1'b0, rready = 1'b0;
    logic [31:0]  wdata = '0;
    logic [3:0]   wstrb = '0;
    logic [3:0]   fifo_full = '0, fifo_empty = '0;
    logic [127:0] fifo_rd_data = '0;

    logic        awready0, wready0, bvalid0, arready0, rvalid0;
    logic [1:0]  bresp0, rresp0;
    logic [31:0] rdata0, wr_data0;
    logic [3:0]  wr_en0, rd_en0;
    logic        awready1, wready1, bvalid1, arready1, rvalid1;
    logic [1:0]  bresp1, rresp1;
    logic [31:0] rdata1, wr_data1;
    logic [2:0]  wr_en1, rd_en1;

    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata, wr_data;
    logic [3:0]  wr_en, rd_en;

    assign awready = sel ? awready1 : awready0;
    assign wready  = sel ? wready1  : wready0;
    assign bvalid  = sel ? bvalid1  : bvalid0;
    assign bresp   = sel ? bresp1   : bresp0;
    assign arready = sel ? arready1 : arready0;
    assign rvalid  = sel ? rvalid1  : rvalid0;
    assign rresp   = sel ? rresp1   : rresp0;
    assign rdata   = sel ? rdata1   : rdata0;
    assign wr_data = sel ? wr_data1 : wr_data0;
    assign wr_en   = sel ? {1'b0, wr_en1} : wr_en0;
    assign rd_en   = sel ? {1'b0, rd_en1} : rd_en0;

    axi_fifo_bridge_mc #(.NUM_CH(4), .READ_EN_MASK(4'b0111)) dut0 (
        .aclk(aclk), .aresetn(aresetn),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid && !sel), .s_axi_awready(awready0),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid && !sel),
        .s_axi_wready(wready0), .s_axi_bresp(bresp0), .s_axi_bvalid(bvalid0),
        .s_axi_bready(bready), .s_axi_araddr(araddr), .s_axi_arvalid(arvalid && !sel),
        .s_axi_arready(arready0), .s_axi_rdata(rdata0), .s_axi_rresp(rresp0),
        .s_axi_rvalid(rvalid0), .s_axi_rready(rready),
        .fifo_wr_data(wr_data0), .fifo_wr_en(wr_en0), .fifo_full(fifo_full),
        .fifo_rd_data(fifo_rd_data), .fifo_rd_en(rd_en0), .fifo_empty(fifo_empty)
    );

    axi_fifo_bridge_mc #(.NUM_CH(3)) dut1 (
        .aclk(aclk), .aresetn(aresetn),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid && sel), .s_axi_awready(awready1),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid && sel),
        .s_axi_wready(wready1), .s_axi_bresp(bresp1), .s_axi_bvalid(bvalid1),
        .s_axi_bready(bready), .s_axi_araddr(araddr), .s_axi_arvalid(arvalid && sel),
        .s_axi_arready(arready1), .s_axi_rdata(rdata1), .s_axi_rresp(rresp1),
        .s_axi_rvalid(rvalid1), .s_axi_rready(rready),
        .fifo_wr_data(wr_data1), .fifo_wr_en(wr_en1), .fifo_full(fifo_full[2:0]),
        .fifo_rd_data(fifo_rd_data[95:0]), .fifo_rd_en(rd_en1), .fifo_empty(fifo_empty[2:0])
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    // Strobe monitor: every cycle a strobe vector is nonzero is counted.
    int          wr_cnt = 0, rd_cnt = 0;
    logic [3:0]  last_wr_en = '0, last_rd_en = '0;
    logic [31:0] last_wr_data = '0;
    int          last_wr_cyc = 0, last_rd_cyc = 0;
    always @(negedge aclk) begin
        if (wr_en != 4'b0) begin
            wr_cnt++;
            last_wr_en   = wr_en;
            last_wr_data = wr_data;
            last_wr_cyc  = cyc;
        end
        if (rd_en != 4'b0) begin
            rd_cnt++;
            last_rd_en  = rd_en;
            last_rd_cyc = cyc;
        end
    end

    // Results of the most recent transactions.
    logic [1:0]  wr_resp, rd_resp;
    logic [31:0] rd_rdata;
    int          hs_cyc, b_cyc, ar_cyc, r_cyc;
    bit          b_stable, aw_rdy_bad, r_stable;

    task automatic do_write(input logic [7:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int w_lead, input int b_hold);
        bit aw_pend, w_pend, a, w, got;
        int k;
        aw_pend = 1; w_pend = 1; k = 0; got = 0;
        b_stable = 1; aw_rdy_bad = 0;
        awaddr = addr; wdata = data; wstrb = strb; bready = 0;
        while ((aw_pend || w_pend) && k < 40) begin
            @(negedge aclk);
            awvalid = aw_pend && (k >= w_lead);
            wvalid  = w_pend;
            a = awvalid && awready;
            w = wvalid && wready;
            if ((a || !aw_pend) && (w || !w_pend)) hs_cyc = cyc;
            @(posedge aclk); #1;
            if (a) begin aw_pend = 0; awvalid = 0; end
            if (w) begin w_pend = 0; wvalid = 0; end
            k++;
        end
        checks++;
        if (aw_pend || w_pend) begin
            errors++;
            $display("FAIL write_accept addr=%h aw_pending=%0d w_pending=%0d required both accepted",
                     addr, aw_pend, w_pend);
            awvalid = 0; wvalid = 0;
        end
        k = 0;
        while (!got && k < 40) begin
            @(negedge aclk);
            if (bvalid) got = 1; else k++;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL write_bvalid addr=%h bvalid never seen within 40 cycles", addr);
        end
        b_cyc = cyc; wr_resp = bresp;
        for (int i = 0; i < b_hold; i++) begin
            @(negedge aclk);
            if (awready) aw_rdy_bad = 1;
            if (!bvalid || bresp !== wr_resp) b_stable = 0;
        end
        bready = 1;
        @(posedge aclk); #1;
        bready = 0;
    endtask

    task automatic do_read(input logic [7:0] addr, input int r_hold);
        bit acc, got;
        int k;
        acc = 0; got = 0; k = 0; r_stable = 1;
        araddr = addr; rready = 0;
        while (!acc && k < 40) begin
            @(negedge aclk);
            arvalid = 1;
            if (arready) begin acc = 1; ar_cyc = cyc; end
            @(posedge aclk); #1;
            k++;
        end
        arvalid = 0;
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL read_accept addr=%h arready never seen within 40 cycles", addr);
        end
        k = 0;
        while (!got && k < 40) begin
            @(negedge aclk);
            if (rvalid) got = 1; else k++;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL read_rvalid addr=%h rvalid never seen within 40 cycles", addr);
        end
        r_cyc = cyc; rd_rdata = rdata; rd_resp = rresp;
        for (int i = 0; i < r_hold; i++) begin
            @(negedge aclk);
            if (!rvalid || rdata !== rd_rdata || rresp !== rd_resp) r_stable = 0;
        end
        rready = 1;
        @(posedge aclk); #1;
        rready = 0;
    endtask

    task automatic test_reset();
        aresetn = 0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        checks++;
        if ({awready, wready, arready} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ready got=%b required=000", {awready, wready, arready});
        end
        checks++;
        if ({bvalid, rvalid} !== 2'b00) begin
            errors++;
            $display("FAIL reset_valid got=%b required=00", {bvalid, rvalid});
        end
        checks++;
        if (wr_en !== 4'b0 || rd_en !== 4'b0 || wr_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_fifo wr_en=%b rd_en=%b wr_data=%h required all zero",
                     wr_en, rd_en, wr_data);
        end
        aresetn = 1;
        @(negedge aclk);
        checks++;
        if ({awready, wready, arready} !== 3'b111) begin
            errors++;
            $display("FAIL reset_release_ready got=%b required=111", {awready, wready, arready});
        end
        $display("test_reset done");
    endtask

    task automatic test_push_pop();
        int w0, r0;
        w0 = wr_cnt;
        do_write(8'h20, 32'hDEADBEEF, 4'hF, 0, 0);
        $display("write 0x20 data=DEADBEEF bresp=%0d hs=%0d wr_en_cyc=%0d b_cyc=%0d",
                 wr_resp, hs_cyc, last_wr_cyc, b_cyc);
        checks++;
        if (wr_cnt - w0 !== 1 || last_wr_en !== 4'b0100) begin
            errors++;
            $display("FAIL push_strobe cycles=%0d wr_en=%b required 1 cycle of 0100",
                     wr_cnt - w0, last_wr_en);
        end
        checks++;
        if (last_wr_data !== 32'hDEADBEEF || wr_resp !== 2'b00) begin
            errors++;
            $display("FAIL push_data wr_data=%h bresp=%0d required DEADBEEF/0", last_wr_data, wr_resp);
        end
        checks++;
        if (last_wr_cyc !== hs_cyc + 1 || b_cyc !== hs_cyc + 2) begin
            errors++;
            $display("FAIL push_latency wr_en at +%0d bvalid at +%0d required +1/+2",
                     last_wr_cyc - hs_cyc, b_cyc - hs_cyc);
        end
        fifo_rd_data[2*32 +: 32] = 32'h12345678;
        r0 = rd_cnt;
        do_read(8'h20, 2);
        $display("read 0x20 rdata=%h rresp=%0d ar=%0d r_cyc=%0d", rd_rdata, rd_resp, ar_cyc, r_cyc);
        checks++;
        if (rd_cnt - r0 !== 1 || last_rd_en !== 4'b0100 || last_rd_cyc !== ar_cyc + 1) begin
            errors++;
            $display("FAIL pop_strobe cycles=%0d rd_en=%b at +%0d required 1 cycle of 0100 at +1",
                     rd_cnt - r0, last_rd_en, last_rd_cyc - ar_cyc);
        end
        checks++;
        if (rd_rdata !== 32'h12345678 || rd_resp !== 2'b00 || !r_stable) begin
            errors++;
            $display("FAIL pop_data rdata=%h rresp=%0d stable=%0d required 12345678/0/1",
                     rd_rdata, rd_resp, r_stable);
        end
        checks++;
        if (r_cyc !== ar_cyc + 2) begin
            errors++;
            $display("FAIL pop_latency rvalid at +%0d required +2", r_cyc - ar_cyc);
        end
    endtask

    task automatic test_overflow();
        int w0;
        fifo_full = 4'b0010;
        w0 = wr_cnt;
        do_write(8'h10, 32'hAAAA5555, 4'hF, 0, 0);
        $display("write 0x10 full bresp=%0d pushes=%0d", wr_resp, wr_cnt - w0);
        checks++;
        if (wr_cnt !== w0 || wr_resp !== 2'b10) begin
            errors++;
            $display("FAIL overflow_write pushes=%0d bresp=%0d required 0/2", wr_cnt - w0, wr_resp);
        end
        do_read(8'h14, 0);
        $display("read 0x14 rdata=%h rresp=%0d", rd_rdata, rd_resp);
        checks++;
        if (rd_rdata !== 32'h6 || rd_resp !== 2'b00) begin
            errors++;
            $display("FAIL overflow_status rdata=%h rresp=%0d required 6/0", rd_rdata, rd_resp);
        end
        do_write(8'h14, 32'h4, 4'hF, 0, 0);
        $display("write 0x14 w1c bresp=%0d", wr_resp);
        checks++;
        if (wr_resp !== 2'b00) begin
            errors++;
            $display("FAIL status_w1c_resp bresp=%0d required 0", wr_resp);
        end
        do_read(8'h14, 0);
        $display("read 0x14 rdata=%h rresp=%0d", rd_rdata, rd_resp);
        checks++;
        if (rd_rdata !== 32'h2) begin
            errors++;
            $display("FAIL overflow_cleared rdata=%h required 2", rd_rdata);
        end
        fifo_full = 4'b0000;
    endtask

    task automatic test_underflow_disabled();
        int r0;
        fifo_empty = 4'b0001;
        r0 = rd_cnt;
        do_read(8'h00, 0);
        $display("read 0x00 empty rdata=%h rresp=%0d", rd_rdata, rd_resp);
        checks++;
        if (rd_rdata !== 32'h0 || rd_resp !== 2'b10 || rd_cnt !== r0) begin
            errors++;
            $display("FAIL underflow_read rdata=%h rresp=%0d pops=%0d required 0/2/0",
                     rd_rdata, rd_resp, rd_cnt - r0);
        end
        do_read(8'h04, 0);
        $display("read 0x04 rdata=%h", rd_rdata);
        checks++;
        if (rd_rdata !== 32'h9) begin
            errors++;
            $display("FAIL underflow_status rdata=%h required 9", rd_rdata);
        end
        fifo_empty = 4'b0000;
        fifo_rd_data[3*32 +: 32] = 32'hCAFE0003;
        do_read(8'h30, 0);
        $display("read 0x30 disabled rdata=%h rresp=%0d", rd_rdata, rd_resp);
        checks++;
        if (rd_resp !== 2'b10 || rd_rdata !== 32'h0 || rd_cnt !== r0) begin
            errors++;
            $display("FAIL disabled_read rdata=%h rresp=%0d pops=%0d required 0/2/0",
                     rd_rdata, rd_resp, rd_cnt - r0);
        end
        do_read(8'h34, 0);
        $display("read 0x34 rdata=%h", rd_rdata);
        checks++;
        if (rd_rdata !== 32'h0) begin
            errors++;
            $display("FAIL disabled_no_flag rdata=%h required 0", rd_rdata);
        end
    endtask

    task automatic test_handshake();
        int w0;
        w0 = wr_cnt;
        do_write(8'h20, 32'h0BADF00D, 4'hF, 3, 5);
        $display("write 0x20 w_lead=3 b_hold=5 bresp=%0d stable=%0d", wr_resp, b_stable);
        checks++;
        if (wr_cnt - w0 !== 1 || last_wr_data !== 32'h0BADF00D || wr_resp !== 2'b00) begin
            errors++;
            $display("FAIL ordered_push pushes=%0d data=%h bresp=%0d required 1/0BADF00D/0",
                     wr_cnt - w0, last_wr_data, wr_resp);
        end
        checks++;
        if (!b_stable || aw_rdy_bad) begin
            errors++;
            $display("FAIL bresp_hold stable=%0d awready_seen=%0d required 1/0", b_stable, aw_rdy_bad);
        end
        w0 = wr_cnt;
        do_write(8'h20, 32'h11112222, 4'h3, 0, 0);
        $display("write 0x20 wstrb=3 bresp=%0d", wr_resp);
        checks++;
        if (wr_cnt !== w0 || wr_resp !== 2'b10) begin
            errors++;
            $display("FAIL partial_strobe pushes=%0d bresp=%0d required 0/2", wr_cnt - w0, wr_resp);
        end
    endtask

    task automatic test_decode();
        int w0, r0;
        sel = 1;
        w0 = wr_cnt; r0 = rd_cnt;
        do_write(8'h30, 32'h33333333, 4'hF, 0, 0);
        $display("dut1 write 0x30 bresp=%0d", wr_resp);
        checks++;
        if (wr_resp !== 2'b10) begin
            errors++;
            $display("FAIL decode_wr_ch bresp=%0d required 2", wr_resp);
        end
        do_write(8'h08, 32'h08080808, 4'hF, 0, 0);
        $display("dut1 write 0x08 bresp=%0d", wr_resp);
        checks++;
        if (wr_resp !== 2'b10) begin
            errors++;
            $display("FAIL decode_wr_rsvd bresp=%0d required 2", wr_resp);
        end
        do_read(8'h30, 0);
        $display("dut1 read 0x30 rdata=%h rresp=%0d", rd_rdata, rd_resp);
        checks++;
        if (rd_resp !== 2'b10 || rd_rdata !== 32'h0) begin
            errors++;
            $display("FAIL decode_rd_ch rdata=%h rresp=%0d required 0/2", rd_rdata, rd_resp);
        end
        do_read(8'h08, 0);
        $display("dut1 read 0x08 rdata=%h rresp=%0d", rd_rdata, rd_resp);
        checks++;
        if (rd_resp !== 2'b10 || rd_rdata !== 32'h0) begin
            errors++;
            $display("FAIL decode_rd_rsvd rdata=%h rresp=%0d required 0/2", rd_rdata, rd_resp);
        end
        checks++;
        if (wr_cnt !== w0 || rd_cnt !== r0) begin
            errors++;
            $display("FAIL decode_strobes pushes=%0d pops=%0d required 0/0", wr_cnt - w0, rd_cnt - r0);
        end
        fifo_empty = 4'b0100;
        do_read(8'h24, 0);
        $display("dut1 read 0x24 rdata=%h rresp=%0d", rd_rdata, rd_resp);
        checks++;
        if (rd_rdata !== 32'h1 || rd_resp !== 2'b00) begin
            errors++;
            $display("FAIL decode_last_ch rdata=%h rresp=%0d required 1/0", rd_rdata, rd_resp);
        end
        fifo_empty = 4'b0000;
        sel = 0;
    endtask

    task automatic test_reset_mid();
        int w0, r0;
        // Re-arm overflow on ch1; underflow on ch0 is still set from earlier.
        fifo_full = 4'b0010;
        do_write(8'h10, 32'h1, 4'hF, 0, 0);
        fifo_full = 4'b0000;
        // Reset lands on the edge that completes AW+W.
        w0 = wr_cnt;
        @(negedge aclk);
        awaddr = 8'h20; wdata = 32'h77777777; wstrb = 4'hF;
        awvalid = 1; wvalid = 1; aresetn = 0;
        @(posedge aclk); #1;
        awvalid = 0; wvalid = 0; aresetn = 1;
        repeat (4) @(negedge aclk);
        $display("reset at handshake pushes=%0d bvalid=%0d", wr_cnt - w0, bvalid);
        checks++;
        if (wr_cnt !== w0 || bvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_wexec pushes=%0d bvalid=%0d required 0/0", wr_cnt - w0, bvalid);
        end
        // Reset while a read response is pending.
        fifo_rd_data[0 +: 32] = 32'h0000A5A5;
        r0 = rd_cnt;
        @(negedge aclk);
        araddr = 8'h00; arvalid = 1;
        @(posedge aclk); #1;
        arvalid = 0;
        @(negedge aclk);
        @(negedge aclk);
        checks++;
        if (rvalid !== 1'b1) begin
            errors++;
            $display("FAIL reset_rresp_pre rvalid=%0d required 1", rvalid);
        end
        aresetn = 0;
        @(posedge aclk); #1;
        aresetn = 1;
        @(negedge aclk);
        $display("reset in R_RESP rvalid=%0d bvalid=%0d pops=%0d", rvalid, bvalid, rd_cnt - r0);
        checks++;
        if (rvalid !== 1'b0 || bvalid !== 1'b0 || rd_cnt - r0 !== 1) begin
            errors++;
            $display("FAIL reset_rresp rvalid=%0d bvalid=%0d pops=%0d required 0/0/1",
                     rvalid, bvalid, rd_cnt - r0);
        end
        do_read(8'h04, 0);
        $display("read 0x04 after reset rdata=%h", rd_rdata);
        checks++;
        if (rd_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_unf_clear rdata=%h required 0", rd_rdata);
        end
        do_read(8'h14, 0);
        $display("read 0x14 after reset rdata=%h", rd_rdata);
        checks++;
        if (rd_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_ovf_clear rdata=%h required 0", rd_rdata);
        end
    endtask

    initial begin
        test_reset();
        test_push_pop();
        test_overflow();
        test_underflow_disabled();
        test_handshake();
        test_decode();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish within 200000 time units");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/axi_fifo_bridge_mc.md
Name: axi_fifo_bridge_mc

Overview:
Multi-channel successor to the single-FIFO AXI4-Lite bridge. One AXI4-Lite subordinate fronts NUM_CH independent FWFT FIFO pairs (push side and pop side per channel) through per-channel address windows. Adds proper AW/W/AR handshaking with one outstanding transaction per direction, a per-channel status register, sticky overflow/underflow flags, and per-channel direction enable masks.

Parameters:
AXI_ADDR_WIDTH, 8, byte address width; must be at least 4+clog2(NUM_CH).
AXI_DATA_WIDTH, 32, data width; fixed at 32 because wstrb is 4 bits.
NUM_CH, 4, number of FIFO channels (1..16).
WRITE_EN_MASK, all ones (NUM_CH bits), bit i=1 enables pushes to channel i.
READ_EN_MASK, all ones (NUM_CH bits), bit i=1 enables pops from channel i.

Ports:
aclk  in  1  clock
aresetn  in  1  synchronous active-low reset
s_axi_awaddr/awvalid/awready  in/in/out  AW/1/1  write address channel
s_axi_wdata/wstrb/wvalid/wready  in/in/in/out  DW/4/1/1  write data channel
s_axi_bresp/bvalid/bready  out/out/in  2/1/1  write response
s_axi_araddr/arvalid/arready  in/in/out  AW/1/1  read address channel
s_axi_rdata/rresp/rvalid/rready  out/out/out/in  DW/2/1/1  read response
fifo_wr_data  out  DW  push data, shared by all channels
fifo_wr_en  out  NUM_CH  one-hot push strobe
fifo_full  in  NUM_CH  per-channel full
fifo_rd_data  in  NUM_CH*DW  FWFT head words; channel i at [i*DW +: DW]
fifo_rd_en  out  NUM_CH  one-hot pop strobe
fifo_empty  in  NUM_CH  per-channel empty

Behaviour:
- Reset (aresetn=0 at posedge): all AXI outputs 0 (awready, wready and arready are 0 during reset); fifo_wr_en=0, fifo_rd_en=0, fifo_wr_data=0; sticky flags cleared; holding registers invalid. An in-flight transaction is dropped, and no strobe is issued in the cycle after reset.
- Address decode: channel ch=addr[4 +: clog2(NUM_CH)], offset=addr[3:2]. Offset 0 is DATA, offset 1 is STATUS, offsets 2 and 3 are reserved. ch>=NUM_CH returns SLVERR.
- STATUS word: bit0 is empty, bit1 is full, bit2 is overflow (sticky), bit3 is underflow (sticky); bits 31:4 read as 0.
- Write path, states W_IDLE -> W_EXEC -> W_RESP -> W_IDLE:
  - awready=1 in W_IDLE while no address is held. wready=1 in W_IDLE while no data is held. AW and W may arrive in either order or in the same cycle.
  - Once both are held, the next cycle is W_EXEC, which is a single cycle.
  - W_EXEC with DATA offset, a valid channel, the WRITE_EN_MASK bit set, wstrb=4'hF and !fifo_full[ch]: fifo_wr_en[ch]=1 for exactly one cycle, fifo_wr_data=held wdata, response OKAY.
  - W_EXEC with DATA offset, the channel enabled, and fifo_full: no push, overflow[ch] set, SLVERR.
  - W_EXEC with DATA offset and wstrb!=4'hF, or the channel disabled: no push, no flag change, SLVERR.
  - W_EXEC with STATUS offset: write-1-to-clear on wdata[3:2], response OKAY.
  - W_EXEC with a reserved offset or invalid channel: SLVERR, no side effects.
  - W_RESP: bvalid=1 with bresp stable until bready. Handshake cycle returns to W_IDLE; the next AW is accepted in the following cycle.
  - Latency: with AW and W accepted at cycle N, fifo_wr_en is high at N+1 and bvalid is first high at N+2.
- Read path, states R_IDLE -> R_EXEC -> R_RESP -> R_IDLE:
  - arready=1 only in R_IDLE.
  - R_EXEC with DATA offset, the READ_EN_MASK bit set and !fifo_empty[ch]: fifo_rd_en[ch]=1 for one cycle, rdata captured from the FWFT head, OKAY.
  - R_EXEC with DATA offset, enabled, and empty: underflow[ch] set, rdata=0, SLVERR.
  - R_EXEC with DATA offset and disabled: rdata=0, SLVERR, no flag change.
  - R_EXEC with STATUS offset: rdata=status sampled in R_EXEC, OKAY, no side effects.
  - R_EXEC with a reserved offset or invalid channel: rdata=0, SLVERR.
  - R_RESP: rvalid, rdata and rresp are held stable until rready.
  - Latency: AR accepted at N, fifo_rd_en high at N+1, rvalid first high at N+2.
- Read and write paths are independent and may execute in the same cycle, including on the same channel.
- Sticky-flag conflicts: a set and a clear of the same bit in one cycle leaves the bit set. An underflow set from the read path and an overflow clear from the write path act on their own bits.
- Strobes: fifo_wr_en and fifo_rd_en are registered outputs, at most one bit high per vector. Busy directions never drop requests; AXI back-pressure is applied instead.

Test Plan:
- Push/pop ch2: write 0xDEADBEEF to 0x20. Expect fifo_wr_en=4'b0100 for 1 cycle with wr_data=0xDEADBEEF and bresp=OKAY. Then read 0x20 with rd_data[2]=0x12345678. Expect rd_en=4'b0100 and rdata=0x12345678, OKAY, rvalid at AR+2.
- Overflow: fifo_full[1]=1, write to 0x10. Expect no wr_en and SLVERR. Read 0x14 returns 0x6 (full + overflow). Write 0x4 to 0x14, then read 0x14 returns 0x2.
- Underflow/disabled: fifo_empty[0]=1, read 0x00 returns rdata=0 with SLVERR and status bit3 set. With READ_EN_MASK[3]=0 and data present, read 0x30 returns SLVERR with no rd_en and no flag.
- Handshake ordering: W presented 3 cycles before AW and bready held low 5 cycles. Expect single push, bvalid stable, awready=0 until the B handshake. Partial wstrb=4'h3 gives SLVERR with no push.
- Decode errors: with NUM_CH=3, accesses to 0x30 and 0x08 return SLVERR with no strobes.
- Reset mid-transaction: assert aresetn=0 in W_EXEC-1 and R_RESP. Expect no strobe afterwards, bvalid=rvalid=0, and sticky flags cleared.
